mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single DDR3 memory port (26-bit word address, 32-bit data, in-order reads) between N_REQ independent requesters, e.g. the GBA bus bridge and the host/debug link.
- Sits between the requesters and the memory-controller wrapper's mux-side signals.
- Grants requests round-robin and holds each granted command stable until the memory side accepts it.
- Tags every read so that in-order read returns are steered back to the requester that issued them.

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_W, 26, memory word address width
DATA_W, 32, data width
MAX_OUTSTANDING, 8, maximum reads granted but not yet returned; power of 2; tag FIFO depth

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_rd  in  N_REQ  per-requester read request; held until req_ack
req_wr  in  N_REQ  per-requester write request; held until req_ack
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_width  in  N_REQ*2  packed byte-width codes (00 none, 01 byte, 10 half, 11 word)
req_wr_data  in  N_REQ*DATA_W  packed write data
req_ack  out  N_REQ  one-cycle pulse: request latched; requester may change or drop it next cycle
rsp_valid  out  N_REQ  one-cycle pulse: rsp_data carries this requester's read data
rsp_data  out  DATA_W  read data, shared by all requesters
mem_addr  out  ADDR_W  command address to memory
mem_rd  out  1  read command valid
mem_wr  out  1  write command valid
mem_data_width  out  2  write byte-width code
mem_wr_data  out  DATA_W  write data
mem_rd_ready  in  1  memory can accept a read this cycle
mem_wr_ready  in  1  memory can accept a write this cycle
mem_rd_data  in  DATA_W  returned read data
mem_rd_valid  in  1  mem_rd_data valid
outstanding  out  $clog2(MAX_OUTSTANDING)+1  reads granted but not yet returned
err_orphan  out  1  sticky: read data arrived with no outstanding read

Behaviour:
- Reset (asynchronous): all outputs 0, FSM = IDLE, tag FIFO empty, outstanding = 0, rr_ptr = N_REQ-1 so requester 0 has first priority.
- Request decode:
  - Requester i is pending if req_rd[i] | req_wr[i].
  - If both bits are set, the request is treated as a read; the write stays pending after the ack.
  - A pending read is eligible only when outstanding < MAX_OUTSTANDING. Pending writes are always eligible.
- Arbitration: among eligible requesters, grant the first index after rr_ptr, wrapping modulo N_REQ. On grant, rr_ptr takes the granted index.
- FSM, two states:
  - IDLE: if any requester is eligible, latch that requester's addr, width, data and command type into the command registers. Pulse req_ack[i] in the same cycle. For a read, push tag i into the FIFO and increment outstanding. Go to ISSUE. If nothing is eligible, stay in IDLE.
  - ISSUE: drive mem_rd or mem_wr (exactly one) from the registers. mem_addr, mem_data_width and mem_wr_data stay constant while waiting.
    - A read is accepted when mem_rd & mem_rd_ready.
    - A write is accepted when mem_wr & mem_wr_ready.
    - On the accept cycle, deassert the command next cycle and return to IDLE. Otherwise stay in ISSUE.
- Throughput: one command per 2 cycles at best. Grant-to-command latency is 1 cycle.
- Read return:
  - On mem_rd_valid, pop the FIFO head tag t.
  - Next cycle: rsp_valid[t] = 1 and rsp_data = the captured mem_rd_data. rsp_valid pulses exactly one cycle per return.
  - Outstanding decrements on the pop.
- Simultaneous push and pop: the FIFO handles both; outstanding stays unchanged.
- Orphan return: mem_rd_valid while the FIFO is empty is dropped, no rsp_valid is raised, and err_orphan sets. err_orphan is cleared only by rst.
- Outstanding never exceeds MAX_OUTSTANDING. When it is full, pending reads are skipped by arbitration and pending writes still proceed.
- Reset mid-operation: an in-flight command is abandoned and the FIFO is cleared. Reads already issued to memory that return later are reported as orphans.
- mem_data_width and mem_wr_data are also driven during reads (don't-care to memory) and keep their latched values.

Test Plan:
- Single read: req_rd[0]=1, addr=0x000123; memory ready → req_ack[0] at cycle 0, mem_rd=1 with mem_addr=0x000123 at cycle 1; mem_rd_valid with data 0xDEADBEEF → rsp_valid[0]=1, rsp_data=0xDEADBEEF one cycle later; outstanding returns to 0.
- Round-robin: both requesters hold req_wr continuously → acks alternate 0,1,0,1; each requester's address and data appear unchanged on the mem_* outputs.
- Backpressure: mem_wr_ready=0 for 5 cycles during ISSUE → mem_wr, mem_addr and mem_wr_data stay stable; no new req_ack; command accepted on the cycle ready rises.
- Tag steering: issue reads 0,1,1,0 with returns delayed until all four are issued → rsp_valid pulses in order 0,1,1,0 with the matching data.
- Outstanding limit: 8 reads issued, none returned → requester 0's 9th read gets no ack while requester 1's write is still acked; one return → 9th read is granted.
- Orphan and reset: mem_rd_valid with an empty FIFO → err_orphan=1, no rsp_valid; rst asserted mid-ISSUE → all outputs 0 immediately (asynchronous), err_orphan cleared.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one in-order DDR3 command port between N_REQ requesters.
// Read returns are steered back to their issuer through a tag FIFO.
module mem_arbiter #(
  parameter int N_REQ           = 2,
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_rd,
  input  logic [N_REQ-1:0]                     req_wr,
  input  logic [N_REQ*ADDR_W-1:0]              req_addr,
  input  logic [N_REQ*2-1:0]                   req_width,
  input  logic [N_REQ*DATA_W-1:0]              req_wr_data,
  output logic [N_REQ-1:0]                     req_ack,
  output logic [N_REQ-1:0]                     rsp_valid,
  output logic [DATA_W-1:0]                    rsp_data,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic                                 mem_rd,
  output logic                                 mem_wr,
  output logic [1:0]                           mem_data_width,
  output logic [DATA_W-1:0]                    mem_wr_data,
  input  logic                                 mem_rd_ready,
  input  logic                                 mem_wr_ready,
  input  logic [DATA_W-1:0]                    mem_rd_data,
  input  logic                                 mem_rd_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 err_orphan
);

  localparam int          PW      = $clog2(MAX_OUTSTANDING);
  localparam int          CW      = PW + 1;
  localparam int          IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NR      = N_REQ;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state, state_next;
  logic [IW-1:0]     rr_ptr;
  logic [N_REQ-1:0]  eligible;
  logic              rd_ok;
  logic              gnt_found;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_rd;
  logic              grant;
  logic              accept;
  logic              push, pop;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [IW-1:0]     tag_mem [MAX_OUTSTANDING];

  // A requester holding both bits is served as a read; when the tag FIFO is
  // full its write bit alone keeps it eligible and it is served as a write.
  always_comb begin
    rd_ok = (count < MAX_CNT);
    for (int unsigned i = 0; i < NR; i++) begin
      eligible[i] = (req_rd[i] & rd_ok) | req_wr[i];
    end
  end

  always_comb begin
    int unsigned j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      j = (32'(rr_ptr) + k) % NR;
      if (!gnt_found && eligible[IW'(j)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
    gnt_rd = req_rd[gnt_idx] & rd_ok;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    accept     = 1'b0;
    req_ack    = '0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          grant      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        accept = (mem_rd & mem_rd_ready) | (mem_wr & mem_wr_ready);
        if (accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Ack is combinational, so it is masked directly while reset is held.
    if (grant && !rst) req_ack[gnt_idx] = 1'b1;
  end

  assign push = grant & gnt_rd;
  assign pop  = mem_rd_valid & (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= IW'(N_REQ - 1);
      mem_addr       <= '0;
      mem_rd         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_data_width <= '0;
      mem_wr_data    <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        rr_ptr         <= gnt_idx;
        mem_addr       <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        mem_data_width <= req_width[gnt_idx*2 +: 2];
        mem_wr_data    <= req_wr_data[gnt_idx*DATA_W +: DATA_W];
        mem_rd         <= gnt_rd;
        mem_wr         <= ~gnt_rd;
      end else if (accept) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[tag_mem[rd_ptr]] <= 1'b1;
        rsp_data                   <= mem_rd_data;
      end
      if (mem_rd_valid && count == '0) err_orphan <= 1'b1;
    end
  end

  assign outstanding = count;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single transactions,
// directed multi-cycle sequences and a randomized run against a queue-based model.
module tb_mem_arbiter;
  localparam int N    = 2;
  localparam int AW   = 26;
  localparam int DW   = 32;
  localparam int MAXO = 8;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_rd, req_wr, req_ack, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_width;
  logic [N*DW-1:0] req_wr_data;
  logic [DW-1:0]   rsp_data, mem_wr_data, mem_rd_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd, mem_wr, mem_rd_ready, mem_wr_ready, mem_rd_valid, err_orphan;
  logic [1:0]      mem_data_width;
  logic [CW-1:0]   outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_width(req_width),
    .req_wr_data(req_wr_data), .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_width(mem_data_width),
    .mem_wr_data(mem_wr_data), .mem_rd_ready(mem_rd_ready), .mem_wr_ready(mem_wr_ready),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .outstanding(outstanding),
    .err_orphan(err_orphan)
  );

  typedef struct {
    logic          rd;
    int            who;
    logic [AW-1:0] addr;
    logic [1:0]    width;
    logic [DW-1:0] data;
    int            delay;
    logic [DW-1:0] rdata;
    logic [N-1:0]  exp_ack;
  } vec_t;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [1:0]    width;
    logic [DW-1:0] data;
  } cmd_t;

  vec_t vecs[6];
  cmd_t agent[N];
  logic agent_on[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_rd = '0;
    req_wr = '0;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [1:0] w, input logic [DW-1:0] d);
    req_rd[i]               = rd;
    req_wr[i]               = wr;
    req_addr[i*AW +: AW]    = a;
    req_width[i*2 +: 2]     = w;
    req_wr_data[i*DW +: DW] = d;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_reqs();
    req_addr = '0; req_width = '0; req_wr_data = '0;
    mem_rd_ready = 1'b0; mem_wr_ready = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    @(posedge clk);
    #4;
    chk("rst_ack", req_ack, 0);
    chk("rst_cmd", {mem_rd, mem_wr}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_orphan", err_orphan, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    step();
    clear_reqs();
    set_req(v.who, v.rd, !v.rd, v.addr, v.width, v.data);
    mem_rd_ready = 1'b0; mem_wr_ready = 1'b0;
    #4;
    chk("vec_ack", req_ack, v.exp_ack);
    chk("vec_cmd_idle", {mem_rd, mem_wr}, 0);
    for (int c = 0; c <= v.delay; c++) begin
      step();
      clear_reqs();
      mem_rd_ready = (c == v.delay);
      mem_wr_ready = (c == v.delay);
      #4;
      chk("vec_cmd", {mem_rd, mem_wr}, {v.rd, !v.rd});
      chk("vec_addr", mem_addr, v.addr);
      chk("vec_width", mem_data_width, v.width);
      chk("vec_wdata", mem_wr_data, v.data);
      chk("vec_no_ack", req_ack, 0);
    end
    step();
    mem_rd_ready = 1'b0; mem_wr_ready = 1'b0;
    #4;
    chk("vec_cmd_drop", {mem_rd, mem_wr}, 0);
    chk("vec_outstanding", outstanding, v.rd ? 1 : 0);
    if (v.rd) begin
      step();
      mem_rd_valid = 1'b1; mem_rd_data = v.rdata;
      #4;
      chk("vec_rsp_early", rsp_valid, 0);
      step();
      mem_rd_valid = 1'b0;
      #4;
      chk("vec_rsp_valid", rsp_valid, v.exp_ack);
      chk("vec_rsp_data", rsp_data, v.rdata);
      chk("vec_out_zero", outstanding, 0);
      step();
      #4;
      chk("vec_rsp_pulse", rsp_valid, 0);
    end
  endtask

  task automatic run_round_robin();
    int e;
    reset_dut();
    step();
    set_req(0, 1'b0, 1'b1, 26'h0AAAA00, 2'b11, 32'h0000_00A0);
    set_req(1, 1'b0, 1'b1, 26'h0BBBB00, 2'b10, 32'h0000_00B1);
    mem_wr_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      #4;
      e = (c / 2) % 2;
      if (c % 2 == 0) begin
        chk("rr_ack", req_ack, 1 << e);
      end else begin
        chk("rr_ack_issue", req_ack, 0);
        chk("rr_mem_wr", mem_wr, 1);
        chk("rr_addr", mem_addr, (e == 0) ? 26'h0AAAA00 : 26'h0BBBB00);
        chk("rr_data", mem_wr_data, (e == 0) ? 32'h0000_00A0 : 32'h0000_00B1);
        chk("rr_width", mem_data_width, (e == 0) ? 2'b11 : 2'b10);
      end
    end
    clear_reqs();
  endtask

  task automatic run_tag_steering();
    int order[4];
    order = '{0, 1, 1, 0};
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      step();
      mem_rd_ready = 1'b1;
      set_req(order[k], 1'b1, 1'b0, 26'(k * 16 + 5), 2'b11, 32'h0);
      #4;
      chk("tag_ack", req_ack, 1 << order[k]);
      step();
      clear_reqs();
      #4;
      chk("tag_mem_rd", mem_rd, 1);
      chk("tag_mem_addr", mem_addr, 26'(k * 16 + 5));
    end
    step();
    #4;
    chk("tag_outstanding", outstanding, 4);
    for (int k = 0; k <= 4; k++) begin
      step();
      mem_rd_valid = (k < 4);
      mem_rd_data  = 32'hC0DE_0000 + 32'(k);
      #4;
      if (k > 0) begin
        chk("tag_rsp_valid", rsp_valid, 1 << order[k-1]);
        chk("tag_rsp_data", rsp_data, 32'hC0DE_0000 + 32'(k - 1));
      end
    end
    chk("tag_out_zero", outstanding, 0);
  endtask

  task automatic run_limit();
    reset_dut();
    for (int k = 0; k < MAXO; k++) begin
      step();
      mem_rd_ready = 1'b1;
      set_req(0, 1'b1, 1'b0, 26'(k), 2'b11, 32'h0);
      #4;
      chk("lim_ack", req_ack, 1);
      step();
      clear_reqs();
      #4;
    end
    step();
    #4;
    chk("lim_count", outstanding, MAXO);
    step();
    set_req(0, 1'b1, 1'b0, 26'h9, 2'b11, 32'h0);
    set_req(1, 1'b0, 1'b1, 26'h77, 2'b01, 32'h55);
    mem_wr_ready = 1'b0;
    #4;
    chk("lim_ack_wr", req_ack, 2'b10);
    step();
    req_wr = '0;
    mem_wr_ready = 1'b1;
    #4;
    chk("lim_issue_wr", mem_wr, 1);
    chk("lim_issue_addr", mem_addr, 26'h77);
    step();
    #4;
    chk("lim_full_skip", req_ack, 0);
    chk("lim_still_full", outstanding, MAXO);
    step();
    mem_rd_valid = 1'b1; mem_rd_data = 32'h99;
    #4;
    chk("lim_pop_cycle", req_ack, 0);
    step();
    mem_rd_valid = 1'b0;
    #4;
    chk("lim_9th_ack", req_ack, 1);
    chk("lim_rsp", rsp_valid, 1);
    chk("lim_count_dec", outstanding, MAXO - 1);
    step();
    clear_reqs();
    #4;
    chk("lim_9th_rd", mem_rd, 1);
    chk("lim_9th_addr", mem_addr, 26'h9);
  endtask

  task automatic run_orphan_reset();
    reset_dut();
    step();
    mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD;
    #4;
    step();
    mem_rd_valid = 1'b0;
    #4;
    chk("orphan_flag", err_orphan, 1);
    chk("orphan_rsp", rsp_valid, 0);
    chk("orphan_count", outstanding, 0);
    step();
    set_req(0, 1'b0, 1'b1, 26'h1234, 2'b11, 32'hFEED);
    mem_wr_ready = 1'b0;
    #4;
    chk("pre_rst_ack", req_ack, 1);
    step();
    clear_reqs();
    #4;
    chk("pre_rst_mem_wr", mem_wr, 1);
    chk("orphan_sticky", err_orphan, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_mem_wr", mem_wr, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_wdata", mem_wr_data, 0);
    chk("async_orphan", err_orphan, 0);
    chk("async_outstanding", outstanding, 0);
    chk("async_ack", req_ack, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic new_req(input int i);
    agent_on[i]     = ($urandom_range(0, 3) != 0);
    agent[i].rd     = 1'($urandom_range(0, 1));
    agent[i].addr   = AW'($urandom);
    agent[i].width  = 2'($urandom);
    agent[i].data   = $urandom;
  endtask

  task automatic run_random(input int cycles);
    int            tagq[$];
    int            mem_pend;
    int            last_gnt;
    int            g;
    int            j;
    logic          busy;
    cmd_t          cur;
    logic          exp_rsp;
    int            exp_tag;
    logic [DW-1:0] exp_rdata;
    reset_dut();
    for (int i = 0; i < N; i++) new_req(i);
    mem_pend = 0; last_gnt = N - 1; busy = 1'b0; exp_rsp = 1'b0; exp_tag = 0; exp_rdata = '0;
    cur = agent[0];
    for (int cyc = 0; cyc < cycles; cyc++) begin
      step();
      for (int i = 0; i < N; i++)
        set_req(i, agent_on[i] & agent[i].rd, agent_on[i] & ~agent[i].rd,
                agent[i].addr, agent[i].width, agent[i].data);
      mem_rd_ready = ($urandom_range(0, 3) != 0);
      mem_wr_ready = ($urandom_range(0, 3) != 0);
      mem_rd_valid = (mem_pend > 0) && ($urandom_range(0, 2) == 0);
      mem_rd_data  = $urandom;
      g = -1;
      if (!busy) begin
        for (int k = 1; k <= N; k++) begin
          j = (last_gnt + k) % N;
          if (g < 0 && agent_on[j] && (!agent[j].rd || tagq.size() < MAXO)) g = j;
        end
      end
      #4;
      chk("rand_ack", req_ack, (g >= 0) ? (1 << g) : 0);
      if (busy) begin
        chk("rand_cmd", {mem_rd, mem_wr}, {cur.rd, !cur.rd});
        chk("rand_addr", mem_addr, cur.addr);
        chk("rand_width", mem_data_width, cur.width);
        chk("rand_wdata", mem_wr_data, cur.data);
      end else begin
        chk("rand_cmd_idle", {mem_rd, mem_wr}, 0);
      end
      chk("rand_outstanding", outstanding, tagq.size());
      chk("rand_rsp_valid", rsp_valid, exp_rsp ? (1 << exp_tag) : 0);
      if (exp_rsp) chk("rand_rsp_data", rsp_data, exp_rdata);
      exp_rsp = 1'b0;
      if (mem_rd_valid) begin
        mem_pend--;
        exp_rsp   = 1'b1;
        exp_tag   = tagq.pop_front();
        exp_rdata = mem_rd_data;
      end
      if (busy) begin
        if (cur.rd ? mem_rd_ready : mem_wr_ready) begin
          busy = 1'b0;
          if (cur.rd) mem_pend++;
        end
      end else if (g >= 0) begin
        busy     = 1'b1;
        cur      = agent[g];
        last_gnt = g;
        if (cur.rd) tagq.push_back(g);
        new_req(g);
      end
      for (int i = 0; i < N; i++)
        if (!agent_on[i] && i != g) new_req(i);
    end
    clear_reqs();
    mem_rd_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 0, 26'h0000123, 2'b11, 32'h0000_0000, 0, 32'hDEADBEEF, 2'b01};
    vecs[1] = '{1'b0, 1, 26'h3FFFFFF, 2'b01, 32'hA5A5A5A5, 5, 32'h0,        2'b10};
    vecs[2] = '{1'b1, 1, 26'h0000000, 2'b10, 32'h1111_2222, 2, 32'h0000_0000, 2'b10};
    vecs[3] = '{1'b0, 0, 26'h2AAAAAA, 2'b10, 32'hFFFFFFFF, 0, 32'h0,        2'b01};
    vecs[4] = '{1'b1, 0, 26'h1555555, 2'b00, 32'h0F0F_0F0F, 3, 32'h12345678, 2'b01};
    vecs[5] = '{1'b0, 1, 26'h0000001, 2'b00, 32'h0000_0000, 1, 32'h0,        2'b10};

    reset_dut();
    foreach (vecs[v]) run_vec(vecs[v]);
    run_round_robin();
    run_tag_steering();
    run_limit();
    run_orphan_reset();
    run_random(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
